mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/param_defs.sv | 25 ++
 rtl/mem_resp_array.sv | 29 ++
 rtl/mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/param_defs.sv
// Shared definitions for the memory responder: bus width, wait-state limit,
// FSM state encoding and the per-port request payload.
package param_defs;

  localparam int unsigned MemBusWidth   = 32;
  localparam int unsigned AddrWidth     = 32;
  localparam int unsigned WaitCyclesMax = 15;
  localparam int unsigned WaitCntWidth  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACC_D = 2'd2,
    ST_ACC_I = 2'd3
  } mem_resp_state_e;

  // One port's request as captured when a transaction is accepted.
  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic [MemBusWidth-1:0] wdata;
    logic                   rd;
    logic                   wr;
  } mem_port_req_t;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word store: one read or write per enabled cycle.
// Contents are deliberately not reset.
module mem_resp_array
  import param_defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [MemBusWidth-1:0] wdata,
  output logic [MemBusWidth-1:0] q
);

  logic [MemBusWidth-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) memory responder in front of a single-port array.
// Wait states exist only when built with MEM_RESPONDER_WAIT_EN defined.
module mem_responder
  import param_defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_clk_en,
  input  logic [AddrWidth-1:0]   core_addr  [2],
  input  logic [1:0]             core_rd_en,
  input  logic [1:0]             core_wr_en,
  input  logic [MemBusWidth-1:0] core_wdata [2],
  output logic [MemBusWidth-1:0] rdata      [2],
  output logic                   ready,
  output logic [1:0]             err
);

  localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS);

  mem_resp_state_e state, state_d;
  logic            drain, drain_d;
  mem_port_req_t   req_q [2];

  logic [1:0]             bad;
  logic [1:0]             pend;
  logic [1:0]             rd_issue;
  logic [1:0]             rd_zero;
  logic [1:0]             cap;
  logic                   req_fire;
  logic                   acc_d;
  logic                   acc_i;
  logic                   mem_en;
  logic                   mem_we;
  logic [IdxWidth-1:0]    mem_idx;
  logic [MemBusWidth-1:0] mem_wdata;
  logic [MemBusWidth-1:0] mem_q;
  logic                   unused_ok;

`ifdef MEM_RESPONDER_WAIT_EN
  localparam int unsigned WaitEff = (WAIT_CYCLES > WaitCyclesMax) ? WaitCyclesMax : WAIT_CYCLES;
  localparam logic [WaitCntWidth-1:0] WaitLoad =
    (WaitEff > 0) ? WaitCntWidth'(WaitEff - 1) : '0;

  logic [WaitCntWidth-1:0] cnt, cnt_d;
`endif

  // Port-0 write data is latched but never stored; the parameter only matters with wait states.
  assign unused_ok = ^{req_q[0].wdata, 32'(WAIT_CYCLES)};

  assign ready    = (state == ST_IDLE);
  assign req_fire = core_clk_en && ((|core_rd_en) || (|core_wr_en));

  // Each access state spends one cycle issuing and, if last, one cycle draining the read.
  assign acc_d = (state == ST_ACC_D) && !drain;
  assign acc_i = (state == ST_ACC_I) && !drain;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bad[p]  = (req_q[p].addr[1:0] != 2'b00) ||
                (req_q[p].addr[AddrWidth-1:IdxWidth+2] != '0);
      pend[p] = req_q[p].rd || req_q[p].wr;
    end
  end

  // Array port steering: data port in ACC_D, fetch port in ACC_I.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = req_q[1].addr[IdxWidth+1:2];
    mem_wdata = req_q[1].wdata;
    rd_issue  = 2'b00;
    rd_zero   = 2'b00;
    if (acc_d) begin
      mem_en      = !bad[1];
      mem_we      = req_q[1].wr;
      rd_issue[1] = !bad[1] && !req_q[1].wr && req_q[1].rd;
      rd_zero[1]  = bad[1] && !req_q[1].wr && req_q[1].rd;
    end else if (acc_i) begin
      mem_idx     = req_q[0].addr[IdxWidth+1:2];
      mem_en      = !bad[0] && req_q[0].rd;
      rd_issue[0] = !bad[0] && req_q[0].rd;
      rd_zero[0]  = bad[0] && req_q[0].rd;
    end
  end

  always_comb begin
    state_d = state;
    drain_d = drain;
`ifdef MEM_RESPONDER_WAIT_EN
    cnt_d   = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (req_fire) begin
`ifdef MEM_RESPONDER_WAIT_EN
          if (WaitEff > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WaitLoad;
          end else begin
            state_d = (core_rd_en[1] || core_wr_en[1]) ? ST_ACC_D : ST_ACC_I;
          end
`else
          state_d = (core_rd_en[1] || core_wr_en[1]) ? ST_ACC_D : ST_ACC_I;
`endif
        end
      end
`ifdef MEM_RESPONDER_WAIT_EN
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d = pend[1] ? ST_ACC_D : ST_ACC_I;
        end else begin
          cnt_d = cnt - WaitCntWidth'(1);
        end
      end
`endif
      ST_ACC_D: begin
        if (!drain) begin
          if (pend[0]) begin
            state_d = ST_ACC_I;
          end else begin
            drain_d = 1'b1;
          end
        end else begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ACC_I: begin
        if (!drain) begin
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      drain <= 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_d;
      drain <= drain_d;
`ifdef MEM_RESPONDER_WAIT_EN
      cnt   <= cnt_d;
`endif
    end
  end

  // Request capture, per-port error flags and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        req_q[p] <= '0;
        rdata[p] <= '0;
      end
      err <= 2'b00;
      cap <= 2'b00;
    end else begin
      cap <= rd_issue;
      if (ready && req_fire) begin
        for (int p = 0; p < 2; p++) begin
          req_q[p] <= '{addr: core_addr[p], wdata: core_wdata[p],
                        rd: core_rd_en[p], wr: core_wr_en[p]};
        end
      end
      if (acc_d) begin
        err[1] <= bad[1];
      end
      if (acc_i) begin
        err[0] <= req_q[0].wr || (req_q[0].rd && bad[0]);
      end
      for (int p = 0; p < 2; p++) begin
        if (rd_zero[p]) begin
          rdata[p] <= '0;
        end else if (cap[p]) begin
          rdata[p] <= mem_q;
        end
      end
    end
  end

  mem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxWidth)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .q     (mem_q)
  );

endmodule
